// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, angle per
// iteration fetched combinationally from an external arctangent table.
module cordic_rotator #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] z_in,
  output logic [31:0] tbl_idx,
  input  logic [31:0] tbl_angle,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last result
  // RUN   | one micro-rotation per edge, cnt = iteration index

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic        [4:0]  cnt;
  logic               last;
  logic signed [31:0] x_r, y_r, z_r;
  logic signed [31:0] x_sh, y_sh;
  logic signed [31:0] x_nx, y_nx, z_nx;

  assign last    = (cnt == 5'(ITER - 1));
  assign busy    = (state == RUN);
  assign tbl_idx = (state == RUN) ? {27'd0, cnt} : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Arithmetic shifts floor negative operands; z = 0 rotates positively.
  always_comb begin
    x_sh = x_r >>> cnt;
    y_sh = y_r >>> cnt;
    if (z_r[31]) begin
      x_nx = x_r + y_sh;
      y_nx = y_r - x_sh;
      z_nx = z_r + $signed(tbl_angle);
    end else begin
      x_nx = x_r - y_sh;
      y_nx = y_r + x_sh;
      z_nx = z_r - $signed(tbl_angle);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 5'd0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      done  <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_r <= $signed(x_in);
            y_r <= $signed(y_in);
            z_r <= $signed(z_in);
            cnt <= 5'd0;
          end
        end
        RUN: begin
          x_r <= x_nx;
          y_r <= y_nx;
          z_r <= z_nx;
          cnt <= cnt + 5'd1;
          if (last) begin
            x_out <= x_nx;
            y_out <= y_nx;
            z_out <= z_nx;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Scoreboard bench for cordic_rotator: a 16-iteration and a 1-iteration
// instance share a small arctangent table; results are checked on done.
module tb_cordic_rotator;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start16, start1;
  logic [31:0] x_in, y_in, z_in;
  logic [31:0] tbl_idx16, tbl_angle16, tbl_idx1, tbl_angle1;
  logic        busy16, done16, busy1, done1;
  logic [31:0] x_out16, y_out16, z_out16, x_out1, y_out1, z_out1;

  int checks = 0;
  int errors = 0;
  res_t q16[$];
  res_t q1[$];
  int done16_count = 0;

  function automatic logic signed [31:0] lut(input logic [31:0] idx);
    case (idx)
      32'd0:   lut = 45;
      32'd1:   lut = 22;
      32'd2:   lut = 11;
      32'd3:   lut = 10;
      32'd4:   lut = 5;
      32'd5:   lut = 2;
      32'd6:   lut = 1;
      default: lut = 0;
    endcase
  endfunction

  assign tbl_angle16 = lut(tbl_idx16);
  assign tbl_angle1  = lut(tbl_idx1);

  cordic_rotator #(.ITER(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .tbl_idx(tbl_idx16), .tbl_angle(tbl_angle16),
    .busy(busy16), .done(done16),
    .x_out(x_out16), .y_out(y_out16), .z_out(z_out16)
  );

  cordic_rotator #(.ITER(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .tbl_idx(tbl_idx1), .tbl_angle(tbl_angle1),
    .busy(busy1), .done(done1),
    .x_out(x_out1), .y_out(y_out1), .z_out(z_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic res_t model(input logic signed [31:0] x0, input logic signed [31:0] y0,
                                 input logic signed [31:0] z0, input int n);
    logic signed [31:0] x, y, z, xs, ys;
    res_t r;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < n; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - lut(32'(i));
      end else begin
        x = x + ys; y = y - xs; z = z + lut(32'(i));
      end
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (done16) begin
      done16_count++;
      if (q16.size() == 0) chk("spurious_done16", 32'(done16), 32'd0);
      else begin
        e = q16.pop_front();
        chk("x_out16", x_out16, e.x);
        chk("y_out16", y_out16, e.y);
        chk("z_out16", z_out16, e.z);
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("spurious_done1", 32'(done1), 32'd0);
      else begin
        e = q1.pop_front();
        chk("x_out1", x_out1, e.x);
        chk("y_out1", y_out1, e.y);
        chk("z_out1", z_out1, e.z);
      end
    end
  end

  // Call at a negedge with start16 driven; returns at the negedge after the sampling edge.
  task automatic issue16(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    x_in = x; y_in = y; z_in = z; start16 = 1'b1;
    q16.push_back(model(x, y, z, 16));
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic wait_done16(input int budget, output int cyc);
    cyc = 0;
    while (!done16 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!done16) chk("timeout_done16", 32'(done16), 32'd1);
  endtask

  initial begin
    int cyc, pulses;
    logic bad;
    rst_n = 1'b0; start16 = 1'b0; start1 = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_tbl_idx", tbl_idx16, 32'd0);
    chk("rst_x_out", x_out16, 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // nominal rotation with idx sequence and exact done timing
    issue16(32'd100, 32'd0, 32'd30);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("nom_idx%0d", i), tbl_idx16, 32'(i));
      chk($sformatf("nom_busy%0d", i), 32'(busy16), 32'd1);
      chk($sformatf("nom_nodone%0d", i), 32'(done16), 32'd0);
      @(negedge clk);
    end
    chk("nom_done", 32'(done16), 32'd1);
    chk("nom_busy_end", 32'(busy16), 32'd0);
    chk("nom_idx_idle", tbl_idx16, 32'd0);
    chk("nom_x", x_out16, 32'd143);
    chk("nom_y", y_out16, 32'd82);
    chk("nom_z", z_out16, 32'd0);
    @(negedge clk);
    chk("nom_done_pulse", 32'(done16), 32'd0);

    // start while busy is ignored
    pulses = done16_count;
    issue16(32'd100, 32'd0, 32'd30);
    repeat (4) @(negedge clk);
    x_in = 32'd7; y_in = 32'd9; z_in = -32'sd80; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (30) @(negedge clk);
    chk("busy_start_pulses", 32'(done16_count - pulses), 32'd1);
    chk("busy_start_x", x_out16, 32'd143);
    chk("busy_start_y", y_out16, 32'd82);

    // random operands against the model
    for (int n = 0; n < 4; n++) begin
      issue16($urandom, $urandom, $urandom_range(0, 400) - 200);
      wait_done16(40, cyc);
      @(negedge clk);
    end
    issue16(32'd100, 32'd0, 32'd30);
    wait_done16(40, cyc);
    @(negedge clk);

    // reset mid-operation: outputs clear at once, aborted run never completes
    x_in = 32'd55; y_in = 32'd66; z_in = 32'd77; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_idx7", tbl_idx16, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_x_out", x_out16, 32'd0);
    chk("abort_y_out", y_out16, 32'd0);
    chk("abort_busy", 32'(busy16), 32'd0);
    chk("abort_tbl_idx", tbl_idx16, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = done16_count;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done16_count - pulses), 32'd0);
    issue16(32'd100, 32'd0, 32'd30);
    bad = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 40) begin
      if (x_out16 != 0 || y_out16 != 0 || z_out16 != 0) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("abort_hold_zero", 32'(bad), 32'd0);
    chk("abort_new_done", 32'(done16), 32'd1);
    chk("abort_new_x", x_out16, 32'd143);
    @(negedge clk);

    // back-to-back with start held high
    x_in = 32'd100; y_in = 32'd0; z_in = 32'd30; start16 = 1'b1;
    q16.push_back(model(32'd100, 32'd0, 32'd30, 16));
    @(negedge clk);
    x_in = '0; y_in = '0; z_in = '0;
    wait_done16(40, cyc);
    q16.push_back(model(32'd0, 32'd0, 32'd0, 16));
    @(negedge clk);
    start16 = 1'b0;
    cyc = 1;
    while (!done16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_spacing", 32'(cyc), 32'd17);
    chk("b2b_x", x_out16, 32'd0);
    chk("b2b_z", z_out16, 32'd0);
    @(negedge clk);

    // single-iteration instance
    x_in = 32'd100; y_in = 32'd0; z_in = -32'sd30; start1 = 1'b1;
    q1.push_back(model(32'd100, 32'd0, -32'sd30, 1));
    @(negedge clk);
    start1 = 1'b0;
    chk("short_busy", 32'(busy1), 32'd1);
    chk("short_nodone", 32'(done1), 32'd0);
    @(negedge clk);
    chk("short_done", 32'(done1), 32'd1);
    chk("short_x", x_out1, 32'd100);
    chk("short_y", y_out1, -32'sd100);
    chk("short_z", z_out1, 32'd15);
    repeat (3) @(negedge clk);

    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_rotator.md
Name: cordic_rotator

Overview:
- Iterative CORDIC engine in rotation mode. It is the initiator side of the arctangent angle table: it drives the table index and consumes the returned angle, one iteration per clock.
- It rotates the vector (x, y) by the integer-degree angle z using shift-add micro-rotations.
- Output gain is not compensated. Scaling by K is the downstream block's job.
- Sits between the system-level request source and the angle-table instance.

Parameters:
- ITER, 16, number of micro-rotations per operation. Legal range 1..16, matching the 16-entry table depth.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising edge while idle.
- x_in  input  32  signed initial x.
- y_in  input  32  signed initial y.
- z_in  input  32  signed rotation angle, integer degrees.
- tbl_idx  output  32  index to angle table (unsigned).
- tbl_angle  input  32  angle returned by table for tbl_idx; combinational, same cycle.
- busy  output  1  high while iterating.
- done  output  1  one-cycle completion pulse.
- x_out  output  32  signed result x.
- y_out  output  32  signed result y.
- z_out  output  32  signed residual angle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, iteration counter=0, internal x/y/z=0.
  - busy=0, done=0, x_out=y_out=z_out=0, tbl_idx=0.
  - Asserting reset mid-operation aborts it; no done pulse is issued.
- FSM states:
  - IDLE -> RUN on a clock edge with start=1. That edge latches x_in/y_in/z_in into the working registers and sets cnt=0.
  - RUN -> IDLE on the edge that performs iteration cnt=ITER-1.
  - There is no other state.
- RUN, per edge, with i=cnt:
  - d=+1 if z>=0 (sign bit 0), otherwise d=-1.
  - x <= x - d*(y>>>i); y <= y + d*(x>>>i); z <= z - d*tbl_angle.
  - All three updates use the pre-edge values.
  - cnt <= cnt+1.
- Arithmetic:
  - 32-bit two's complement; overflow wraps silently.
  - >>> is an arithmetic shift, so negative operands floor, e.g. -1>>>k = -1.
- tbl_idx:
  - equals zero-extended cnt while in RUN, 0 in IDLE.
  - tbl_angle is used only in RUN.
- Timing, with start sampled at edge k:
  - busy=1 from edge k through edge k+ITER, deasserted at edge k+ITER.
  - Iterations 0..ITER-1 occur at edges k+1..k+ITER.
  - At edge k+ITER: x_out/y_out/z_out <= final values and done <= 1.
  - At edge k+ITER+1: done <= 0.
  - Latency is therefore ITER+1 edges from start to the done-high cycle.
- Outputs hold their last result until the next completion. They are never updated mid-operation.
- start while busy=1 is ignored; no queueing.
- start=1 during the done-high cycle is accepted, since the state is already IDLE. This allows back-to-back operations every ITER+1 cycles.
- start held high continuously gives back-to-back operations.
- z=0 is treated as positive (d=+1).

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-clock, no start.
  - Required: all outputs 0 immediately (asynchronous); busy=0; done=0; tbl_idx=0.
- Nominal rotation:
  - Stimulus: table {45,22,11,10,5,2,1,0...}, ITER=16, x_in=100, y_in=0, z_in=30, start pulsed at edge k.
  - Required: done high exactly one cycle after edge k+16; x_out=143, y_out=82, z_out=0.
  - Required: tbl_idx sequence 0,1,...,15 observed on consecutive RUN cycles.
- Start while busy:
  - Stimulus: start with x=100, y=0, z=30; re-pulse start with different operands at edge k+5.
  - Required: second request ignored; single done pulse; result 143/82/0.
- Back-to-back:
  - Stimulus: hold start=1 for two operations, (100,0,30) then (0,0,0).
  - Required: two done pulses spaced 17 cycles apart; second result 0/0/0.
- Reset mid-operation:
  - Stimulus: pull rst_n low at iteration 7, release, then start (100,0,30).
  - Required: no done from the aborted run; outputs 0 until the new done; new result 143/82/0.
- Short run:
  - Stimulus: ITER=1, x=100, y=0, z=-30.
  - Required: done one cycle after the start-sample edge +1; x_out=100, y_out=-100, z_out=15.
